// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared SPI types and constants used by the master, slave and RAM.
package spi_master_pkg;

    localparam int MEM_WIDTH = 8;

    typedef enum logic [2:0] {IDLE, SEL, CMD, SHIFT, WAIT_RD, CAPTURE, END} state_t;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    localparam logic SLAVE_SELECTED     = 1'b0;
    localparam logic SLAVE_NOT_SELECTED = 1'b1;

endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: host command/response handshake plus the SPI pins of the master.
interface spi_master_if #(parameter int W = spi_master_pkg::MEM_WIDTH) ();

    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         rsp_valid;
    logic [W-1:0] rsp_data;
    logic         busy;
    logic         SS_n;
    logic         MOSI;
    logic         MISO;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, MISO,
        output cmd_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, MISO,
        input  cmd_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
    );

endinterface

// File: rtl/spi_master.sv
// spi_master: issues one {op, data} SPI frame per accepted command; read-data frames
// wait RD_LATENCY cycles then capture MEM_WIDTH bits of MISO into rsp_data.
module spi_master import spi_master_pkg::*; #(
    parameter int MEM_WIDTH  = spi_master_pkg::MEM_WIDTH,
    parameter int RD_LATENCY = 2
) (
    input logic          clk,
    input logic          rst_n,
    spi_master_if.master bus
);

    localparam int FW = MEM_WIDTH + 2;

    state_t        state, next;
    logic [FW-1:0] sr;
    logic [1:0]    op;
    logic [3:0]    cnt;
    logic          hs, last;

    assign hs = bus.cmd_valid && bus.cmd_ready;

    // One counter serves SHIFT, WAIT_RD and CAPTURE; only the terminal value differs.
    always_comb begin
        last = (state == SHIFT)   ? cnt == 4'(FW - 1)
             : (state == WAIT_RD) ? cnt == 4'(RD_LATENCY - 1)
             : cnt == 4'(MEM_WIDTH - 1);
        next = state;
        case (state)
            IDLE:    next = hs ? SEL : IDLE;
            SEL:     next = CMD;
            CMD:     next = SHIFT;
            SHIFT:   next = !last ? SHIFT : (op == RD_DATA) ? WAIT_RD : END;
            WAIT_RD: next = last ? CAPTURE : WAIT_RD;
            CAPTURE: next = last ? END : CAPTURE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    // Outputs are decoded from the next state so they flip on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr            <= '0;
            op            <= WR_ADDR;
            cnt           <= '0;
            bus.SS_n      <= SLAVE_NOT_SELECTED;
            bus.MOSI      <= 1'b0;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
        end else begin
            cnt <= (next != state || state == IDLE) ? 4'd0 : cnt + 4'd1;
            if (hs) begin
                sr <= {bus.cmd_op, bus.cmd_data};
                op <= bus.cmd_op;
            end else if (next == SHIFT) begin
                sr <= sr << 1;
            end else if (state == CAPTURE) begin
                sr <= {sr[FW-2:0], bus.MISO};
            end
            if (state == CAPTURE && next == END) bus.rsp_data <= {sr[MEM_WIDTH-2:0], bus.MISO};
            bus.MOSI      <= (next == CMD || next == SHIFT) && sr[FW-1];
            bus.SS_n      <= (next == IDLE || next == END) ? SLAVE_NOT_SELECTED : SLAVE_SELECTED;
            bus.cmd_ready <= next == IDLE;
            bus.busy      <= next != IDLE;
            bus.rsp_valid <= next == END && op == RD_DATA;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed and random frames against a behavioural SPI slave/RAM model.
module tb_spi_master;
    import spi_master_pkg::*;

    localparam int W = MEM_WIDTH;
    localparam int L = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] ram [2**W];
    logic [W-1:0] addr_m;

    spi_master_if #(.W(W)) bus ();

    spi_master #(.MEM_WIDTH(W), .RD_LATENCY(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame n counts negedges after the handshake edge; the slave sees MOSI of negedge n
    // on the following posedge and the master samples MISO driven at negedge n there too.
    task automatic frame(input logic [1:0] op, input logic [W-1:0] data, input bit hold, input int abort_at);
        int           len, ss_low, rv;
        bit           busy_ok, ready_low;
        logic [W+2:0] mosi_q;
        logic [W-1:0] rd_exp;
        len       = (op == RD_DATA) ? 13 + L + W : 13;
        ss_low    = 0;
        rv        = 0;
        busy_ok   = 1'b1;
        ready_low = 1'b1;
        mosi_q    = '0;
        rd_exp    = ram[addr_m];
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        for (int i = 0; i < 20 && !bus.cmd_ready; i++) @(negedge clk);
        chk("ready_idle", bus.cmd_ready, 1);
        @(posedge clk);
        for (int n = 1; n <= len + 1; n++) begin
            @(negedge clk);
            if (n == 1 && !hold) bus.cmd_valid = 1'b0;
            if (n == 1 && hold) bus.cmd_op = ~op;
            if (n == len) bus.cmd_valid = 1'b0;
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_ss", bus.SS_n, 1);
                chk("abort_mosi", bus.MOSI, 0);
                chk("abort_busy", bus.busy, 0);
                repeat (2) @(negedge clk);
                chk("abort_rsp_valid", bus.rsp_valid, 0);
                rst_n   = 1'b1;
                bus.MISO = 1'b0;
                @(negedge clk);
                chk("abort_ready", bus.cmd_ready, 1);
                return;
            end
            if (n < len) begin
                if (bus.SS_n == 1'b0) ss_low++;
                busy_ok   &= bus.busy;
                ready_low &= !bus.cmd_ready;
            end
            if (bus.rsp_valid) rv++;
            if (n >= 2 && n <= 12) mosi_q = {mosi_q[W+1:0], bus.MOSI};
            if (n == len) begin
                chk("end_ss", bus.SS_n, 1);
                chk("end_busy", bus.busy, 1);
                chk("end_rsp_valid", bus.rsp_valid, op == RD_DATA);
                if (op == RD_DATA) chk("rsp_data", bus.rsp_data, rd_exp);
            end
            if (n == len + 1) begin
                chk("idle_ss", bus.SS_n, 1);
                chk("idle_busy", bus.busy, 0);
                chk("idle_ready", bus.cmd_ready, 1);
            end
            bus.MISO = (op == RD_DATA && n >= 13 + L && n < 13 + L + W) ? rd_exp[W - 1 - (n - 13 - L)] : 1'($urandom);
        end
        chk("ss_low_cycles", ss_low, len - 1);
        chk("mosi_bits", mosi_q, {op[1], op, data});
        chk("rsp_pulses", rv, op == RD_DATA);
        chk("busy_in_frame", busy_ok, 1);
        chk("ready_low_in_frame", ready_low, 1);
        if (op == WR_ADDR || op == RD_ADDR) addr_m = data;
        if (op == WR_DATA) ram[addr_m] = data;
    endtask

    initial begin
        logic [1:0] rop;
        foreach (ram[i]) ram[i] = W'($urandom);
        addr_m        = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = WR_ADDR;
        bus.cmd_data  = '0;
        bus.MISO      = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ss", bus.SS_n, 1);
        chk("rst_mosi", bus.MOSI, 0);
        chk("rst_ready", bus.cmd_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", bus.cmd_ready, 1);

        frame(WR_ADDR, 8'h5A, 1'b0, 0);
        frame(WR_ADDR, 8'h10, 1'b0, 0);
        frame(WR_DATA, 8'hC3, 1'b0, 0);
        frame(RD_ADDR, 8'h10, 1'b0, 0);
        frame(RD_DATA, 8'h00, 1'b0, 0);
        chk("rsp_c3", bus.rsp_data, 8'hC3);

        frame(WR_ADDR, 8'h22, 1'b1, 0);
        @(negedge clk);
        chk("no_queued_frame", bus.busy, 0);

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom);
            frame(rop, W'($urandom), 1'b0, 0);
        end

        frame(RD_DATA, 8'h00, 1'b0, 8);
        frame(RD_DATA, 8'h00, 1'b0, 0);

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = WR_ADDR;
        bus.cmd_data  = 8'h77;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rel_ready0", bus.cmd_ready, 0);
        @(negedge clk);
        chk("rel_ready1", bus.cmd_ready, 1);
        chk("rel_ss_high", bus.SS_n, 1);
        @(negedge clk);
        chk("rel_sel_ss", bus.SS_n, 0);
        chk("rel_sel_busy", bus.busy, 1);
        chk("rel_sel_ready", bus.cmd_ready, 0);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 30 && bus.busy; i++) @(negedge clk);
        chk("rel_done", bus.busy, 0);
        addr_m = 8'h77;
        frame(RD_DATA, 8'h00, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
